// File: rtl/spi_reg_pkg.sv
// Shared types and sizing helpers for the SPI register-bus slave.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } spi_state_e;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    function automatic int frame_bits(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

    function automatic int cnt_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchroniser for one SPI pin, with rise/fall pulses taken
// from the last two stages.
module spi_in_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], i_in};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_level = sync_q[STAGES-1];
    assign o_rise  = sync_q[STAGES-2] & ~sync_q[STAGES-1];
    assign o_fall  = ~sync_q[STAGES-2] & sync_q[STAGES-1];

endmodule

// File: rtl/spi_reg_slave.sv
// SPI slave bridging {rw, addr, data} frames onto a register bus; all logic on i_clk.
// Define SPI_BURST_EN for address auto-increment; otherwise extra words are ignored.
//
// state | meaning
// IDLE  | no frame, waiting for ss_n to fall
// CMD   | shifting in rw + address
// DATA  | shifting data word (and driving MISO on reads)
// HOLD  | word done, ignoring SCK until ss_n rises
module spi_reg_slave
    import spi_reg_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sck,
    input  logic              i_ss_n,
    input  logic              i_spi_mosi,
    output logic              o_spi_miso,
    output logic              o_spi_miso_oe,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_wr_en,
    output logic              o_rd_en,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_busy,
    output logic              o_frame_err
);

    localparam int FRAME_BITS = frame_bits(ADDR_W, DATA_W);
    localparam int CNT_W      = cnt_width(FRAME_BITS);
    localparam int SH_W       = (1 + ADDR_W > DATA_W) ? 1 + ADDR_W : DATA_W;

    logic sck_rise, sck_fall, sck_lvl_unused;
    logic ss_rise, ss_fall, ss_lvl_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .i_clk(i_clk), .i_rst(i_rst), .i_in(i_sck),
        .o_level(sck_lvl_unused), .o_rise(sck_rise), .o_fall(sck_fall)
    );

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .i_clk(i_clk), .i_rst(i_rst), .i_in(i_ss_n),
        .o_level(ss_lvl_unused), .o_rise(ss_rise), .o_fall(ss_fall)
    );

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .i_clk(i_clk), .i_rst(i_rst), .i_in(i_spi_mosi),
        .o_level(mosi_s), .o_rise(mosi_rise_unused), .o_fall(mosi_fall_unused)
    );

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SH_W-2:0]   sh_q, sh_d;
    logic [SH_W-1:0]   sh_nx;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic              rd_pend_q, rd_pend_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              word_done;

    assign sh_nx = {sh_q, mosi_s};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        tx_d      = tx_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        rd_pend_d = rd_en_q;
        err_d     = 1'b0;
        busy_d    = busy_q;
        word_done = 1'b0;

        // Bus returns read data the cycle after the strobe.
        if (rd_pend_q) begin
            tx_d = i_rdata;
        end
`ifdef SPI_BURST_EN
        // Write address advances only after its strobe has been seen.
        if (wr_en_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end
`endif

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d = CMD;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            CMD: begin
                if (sck_rise) begin
                    sh_d = sh_nx[SH_W-2:0];
                    if (cnt_q == CNT_W'(ADDR_W)) begin
                        word_done = 1'b1;
                        cnt_d     = '0;
                        rw_d      = sh_nx[ADDR_W];
                        addr_d    = sh_nx[ADDR_W-1:0];
                        rd_en_d   = (sh_nx[ADDR_W] == RW_READ);
                        state_d   = DATA;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DATA: begin
                // The fall right after a word boundary presents the MSB without shifting.
                if (sck_fall && cnt_q != '0) begin
                    tx_d = tx_q << 1;
                end
                if (sck_rise) begin
                    sh_d = sh_nx[SH_W-2:0];
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        word_done = 1'b1;
                        cnt_d     = '0;
                        if (rw_q == RW_WRITE) begin
                            wdata_d = sh_nx[DATA_W-1:0];
                            wr_en_d = 1'b1;
                        end
`ifdef SPI_BURST_EN
                        if (rw_q == RW_READ) begin
                            addr_d  = addr_q + ADDR_W'(1);
                            rd_en_d = 1'b1;
                        end
`else
                        state_d = HOLD;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
            end
            default: state_d = IDLE;
        endcase

        if (ss_rise) begin
            if ((state_q == CMD || state_q == DATA) && cnt_q != '0 && !word_done) begin
                err_d = 1'b1;
            end
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            tx_q      <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_pend_q <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            tx_q      <= tx_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            rd_pend_q <= rd_pend_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign o_spi_miso    = (state_q == DATA && rw_q == RW_READ) ? tx_q[DATA_W-1] : 1'b0;
    assign o_spi_miso_oe = busy_q;
    assign o_busy        = busy_q;
    assign o_addr        = addr_q;
    assign o_wdata       = wdata_q;
    assign o_wr_en       = wr_en_q;
    assign o_rd_en       = rd_en_q;
    assign o_frame_err   = err_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Scoreboard bench for spi_reg_slave: a frame-level model queues expected bus events,
// a monitor pops them as strobes appear; MISO words are checked per read frame.
module tb_spi_reg_slave;

    localparam int A    = 7;
    localparam int D    = 8;
    localparam int S    = 2;
    localparam int HALF = 8;
`ifdef SPI_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck = 1'b0, ss_n = 1'b1, mosi = 1'b0;
    logic miso, miso_oe, wr_en, rd_en, busy, ferr;
    logic [A-1:0] addr;
    logic [D-1:0] wdata, rdata;

    always #5 clk = ~clk;

    spi_reg_slave #(.ADDR_W(A), .DATA_W(D), .SYNC_STAGES(S)) dut (
        .i_clk(clk), .i_rst(rst), .i_sck(sck), .i_ss_n(ss_n), .i_spi_mosi(mosi),
        .o_spi_miso(miso), .o_spi_miso_oe(miso_oe), .o_addr(addr), .o_wdata(wdata),
        .o_wr_en(wr_en), .o_rd_en(rd_en), .i_rdata(rdata), .o_busy(busy),
        .o_frame_err(ferr)
    );

    typedef struct {
        int kind;   // 0 write, 1 read, 2 frame error
        int addr;
        int data;
    } ev_t;

    ev_t  expq[$];
    int   vectors = 0;
    int   errors  = 0;
    logic [D-1:0] mem [0:(1<<A)-1];
    bit   txb[$];
    bit   rxb[$];
    int   wq[$];

    always @(posedge clk or posedge rst) begin
        if (rst) rdata <= '0;
        else if (rd_en) rdata <= mem[addr];
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void pop_check(int kind, int a, int d);
        ev_t ev;
        if (expq.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d addr %0h, expected no event at %0t",
                     kind, a, $time);
        end else begin
            ev = expq.pop_front();
            check("event_kind", kind, ev.kind);
            if (kind != 2) check("event_addr", a, ev.addr);
            if (kind == 0) check("event_wdata", d, ev.data);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) pop_check(0, int'(addr), int'(wdata));
            if (rd_en) pop_check(1, int'(addr), 0);
            if (ferr)  pop_check(2, 0, 0);
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int nbits);
        rxb.delete();
        ss_n = 1'b0;
        wait_clks(HALF);
        for (int i = 0; i < nbits; i++) begin
            mosi = txb[i];
            wait_clks(HALF);
            if (i == 0) check("busy_in_frame", {busy, miso_oe}, 2'b11);
            rxb.push_back(miso);
            sck = 1'b1;
            wait_clks(HALF);
            sck = 1'b0;
        end
        wait_clks(HALF);
        ss_n = 1'b1;
        wait_clks(S + 1);
        check("busy_released", {busy, miso_oe}, 2'b00);
        wait_clks(4 * HALF);
    endtask

    // Expected events derived from frame length alone: complete words count, a
    // trailing partial word is an error, non-burst builds honour only the first word.
    task automatic run_frame(input bit rw, input int a0, input int nbits);
        int dbits, nw, rem, eff, nrd, v;
        bit err;
        dbits = nbits - 1 - A;
        while (dbits > 0 && wq.size() < (dbits + D - 1) / D) wq.push_back($urandom_range(0, 255));
        txb.delete();
        txb.push_back(rw);
        for (int b = A - 1; b >= 0; b--) txb.push_back(a0[b]);
        foreach (wq[i]) for (int b = D - 1; b >= 0; b--) txb.push_back(wq[i][b]);
        while (txb.size() > nbits) void'(txb.pop_back());

        nw = 0;
        if (dbits < 0) begin
            if (nbits > 0) expq.push_back('{2, 0, 0});
        end else begin
            nw  = dbits / D;
            rem = dbits % D;
            eff = BURST ? nw : (nw > 0 ? 1 : 0);
            err = BURST ? (rem > 0) : (nw == 0 && rem > 0);
            if (rw) begin
                for (int i = 0; i < eff; i++) begin
                    expq.push_back('{0, (a0 + i) % (1 << A), wq[i]});
                    mem[(a0 + i) % (1 << A)] = D'(wq[i]);
                end
            end else begin
                nrd = BURST ? nw + 1 : 1;
                for (int i = 0; i < nrd; i++) expq.push_back('{1, (a0 + i) % (1 << A), 0});
            end
            if (err) expq.push_back('{2, 0, 0});
        end

        send_frame(nbits);

        if (dbits >= D) begin
            eff = BURST ? nw : 1;
            for (int i = 0; i < eff; i++) begin
                v = 0;
                for (int b = 0; b < D; b++) v = (v << 1) | int'(rxb[1 + A + i * D + b]);
                if (rw) check("miso_quiet_on_write", v, 0);
                else    check("miso_read_word", v, int'(mem[(a0 + i) % (1 << A)]));
            end
        end
        wq.delete();
    endtask

    initial begin
        int rw, a0, nw, nb;
        for (int i = 0; i < (1 << A); i++) mem[i] = D'($urandom);

        wait_clks(3);
        check("reset_outputs", {miso, miso_oe, addr, wdata, wr_en, rd_en, busy, ferr}, 0);
        rst = 1'b0;
        wait_clks(4);
        check("idle_outputs", {miso, miso_oe, addr, wdata, wr_en, rd_en, busy, ferr}, 0);

        wq = '{32'hA5};
        run_frame(1'b1, 32'h05, 16);

        mem[7'h12] = 8'h3C;
        run_frame(1'b0, 32'h12, 16);

        wq = '{32'h11, 32'h22, 32'h33};
        run_frame(1'b1, 32'h7E, 32);

        wq = '{32'h9C};
        run_frame(1'b1, 32'h22, 1 + A + 4);

        wq = '{32'h01, 32'hEE, 32'hEE};
        run_frame(1'b1, 32'h01, 32);

        // Reset mid-command: bus must stay silent and the next clean frame must land.
        ss_n = 1'b0;
        wait_clks(HALF);
        for (int i = 0; i < 4; i++) begin
            mosi = i[0];
            wait_clks(HALF);
            sck = 1'b1;
            wait_clks(HALF);
            sck = 1'b0;
        end
        rst = 1'b1;
        wait_clks(2);
        check("reset_mid_frame", {miso, miso_oe, addr, wdata, wr_en, rd_en, busy, ferr}, 0);
        ss_n = 1'b1;
        wait_clks(4);
        rst = 1'b0;
        wait_clks(4);
        wq = '{32'h55};
        run_frame(1'b1, 32'h01, 16);

        for (int f = 0; f < 30; f++) begin
            rw = $urandom_range(0, 1);
            a0 = $urandom_range(0, (1 << A) - 1);
            nw = $urandom_range(1, 3);
            nb = 1 + A + nw * D;
            if ($urandom_range(0, 3) == 0) nb = $urandom_range(1, nb - 1);
            run_frame(rw[0], a0, nb);
        end

        wait_clks(20);
        check("scoreboard_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
